// File: rtl/mems_scan_gen.sv
// MEMS scan timing generator: line/frame request flags at a fixed cycle
// cadence, with run control, line index, scan direction and overrun count.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   enable                level, high = run, low = return to IDLE
//   single_shot           level, high = halt after the next frame event
//   new_line_FIFO_done    ack strobe for new_line
//   new_frame_FIFO_done   ack strobe for new_frame
//   clr_overrun           clears overrun_cnt
//   new_line, new_frame   sticky request flags
//   line_idx              index of the line being scanned
//   scan_dir              current scan direction (BIDIR only)
//   overrun_cnt, overrun  saturating missed-ack count, and its non-zero flag
module mems_scan_gen #(
    parameter int CNTR_W          = 30,
    parameter int LINE_PERIOD     = 550001,
    parameter int LINE_W          = 8,
    parameter int LINES_PER_FRAME = 16,
    parameter bit BIDIR           = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              single_shot,
    input  logic              new_line_FIFO_done,
    input  logic              new_frame_FIFO_done,
    input  logic              clr_overrun,
    output logic              new_line,
    output logic              new_frame,
    output logic [LINE_W-1:0] line_idx,
    output logic              scan_dir,
    output logic [7:0]        overrun_cnt,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [CNTR_W-1:0] CNT_LAST  = CNTR_W'(LINE_PERIOD - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);

    state_t            state, state_nxt;
    logic [CNTR_W-1:0] cnt, cnt_nxt;
    logic [LINE_W-1:0] line_cnt_nxt;
    logic              dir_nxt;
    logic              line_evt, frame_evt;
    logic              line_flag_nxt, frame_flag_nxt;
    logic              miss;
    logic [7:0]        ovr_nxt;

    // Sequencing: state, period counter, line counter, direction.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        line_cnt_nxt = line_idx;
        dir_nxt      = scan_dir;
        line_evt     = 1'b0;
        frame_evt    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt      = '0;
                line_cnt_nxt = '0;
                dir_nxt      = 1'b0;
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (!enable) begin
                    // Dropping enable suppresses any event due this cycle.
                    state_nxt    = IDLE;
                    cnt_nxt      = '0;
                    line_cnt_nxt = '0;
                    dir_nxt      = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    dir_nxt = BIDIR ? ~scan_dir : 1'b0;
                    if (line_idx == LINE_LAST) begin
                        frame_evt    = 1'b1;
                        line_cnt_nxt = '0;
                        if (single_shot) state_nxt = HALT;
                    end else begin
                        line_evt     = 1'b1;
                        line_cnt_nxt = line_idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HALT: begin
                cnt_nxt      = '0;
                line_cnt_nxt = '0;
                if (!enable) begin
                    state_nxt = IDLE;
                    dir_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                cnt_nxt      = '0;
                line_cnt_nxt = '0;
                dir_nxt      = 1'b0;
            end
        endcase
    end

    // Request flags and overrun accounting. A new event beats a same-cycle
    // ack; an event landing on a still-pending flag without ack is a miss.
    always_comb begin
        line_flag_nxt  = line_evt | (new_line & ~new_line_FIFO_done);
        frame_flag_nxt = frame_evt | (new_frame & ~new_frame_FIFO_done);
        miss = (line_evt & new_line & ~new_line_FIFO_done)
             | (frame_evt & new_frame & ~new_frame_FIFO_done);
        ovr_nxt = overrun_cnt;
        if (clr_overrun) begin
            ovr_nxt = '0;
        end else if (miss && overrun_cnt != 8'hFF) begin
            ovr_nxt = overrun_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            line_idx    <= '0;
            scan_dir    <= 1'b0;
            new_line    <= 1'b0;
            new_frame   <= 1'b0;
            overrun_cnt <= '0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            line_idx    <= line_cnt_nxt;
            scan_dir    <= dir_nxt;
            new_line    <= line_flag_nxt;
            new_frame   <= frame_flag_nxt;
            overrun_cnt <= ovr_nxt;
            overrun     <= (ovr_nxt != 8'd0);
        end
    end

endmodule
